// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops 32-bit words from a registered-read FIFO and sends
// each one as BYTES 8N1 UART frames, least-significant byte first.
module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              word_done
);

    localparam int BYTES  = DATA_W / 8;
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    baud_cnt;
    logic [CNT_W-1:0]    baud_cnt_d;
    logic [2:0]          bit_idx;
    logic [2:0]          bit_idx_d;
    logic [BYTE_W-1:0]   byte_idx;
    logic [BYTE_W-1:0]   byte_idx_d;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_d;
    logic                tx_d;
    logic                fifo_rd_d;
    logic                busy_d;
    logic                word_done_d;
    logic                bit_end;
    logic                last_bit;
    logic                last_byte;
    logic                can_fetch;

    assign bit_end   = (baud_cnt == CNT_LAST);
    assign last_bit  = (bit_idx == 3'd7);
    assign last_byte = (byte_idx == BYTE_LAST);
    // The FIFO flag is only consulted where a new word may start.
    assign can_fetch = en && !fifo_empty;

    // State register; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (can_fetch) next_state = FETCH;
            FETCH: next_state = LATCH;
            LATCH: next_state = START;
            START: if (bit_end) next_state = DATA;
            DATA:  if (bit_end && last_bit) next_state = STOP;
            STOP: begin
                if (bit_end) begin
                    if (!last_byte)     next_state = START;
                    else if (can_fetch) next_state = FETCH;
                    else                next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, counters and shift register.
    // tx is derived from the state being entered so it is already correct
    // in the first cycle of every start, data and stop bit.
    always_comb begin
        shreg_d     = shreg;
        bit_idx_d   = bit_idx;
        byte_idx_d  = byte_idx;
        baud_cnt_d  = '0;
        fifo_rd_d   = (next_state == FETCH);
        busy_d      = (next_state != IDLE);
        word_done_d = (state == STOP) && bit_end && last_byte;

        if (state == LATCH) begin
            shreg_d = fifo_data;
        end else if (state == DATA && bit_end) begin
            shreg_d = shreg >> 1;
        end

        if (state != DATA) begin
            bit_idx_d = '0;
        end else if (bit_end) begin
            bit_idx_d = last_bit ? 3'd0 : bit_idx + 3'd1;
        end

        if (state == LATCH) begin
            byte_idx_d = '0;
        end else if (state == STOP && bit_end) begin
            byte_idx_d = last_byte ? '0 : byte_idx + BYTE_W'(1);
        end

        if ((state == START || state == DATA || state == STOP) &&
            next_state == state && !bit_end) begin
            baud_cnt_d = baud_cnt + CNT_W'(1);
        end

        if (next_state == DATA) begin
            tx_d = shreg_d[0];
        end else begin
            tx_d = (next_state != START);
        end
    end

    // Output, counter and data registers; tx goes high at once on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx        <= 1'b1;
            fifo_rd   <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
        end else begin
            tx        <= tx_d;
            fifo_rd   <= fifo_rd_d;
            busy      <= busy_d;
            word_done <= word_done_d;
            baud_cnt  <= baud_cnt_d;
            bit_idx   <= bit_idx_d;
            byte_idx  <= byte_idx_d;
            shreg     <= shreg_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: directed bench for fifo_uart_drain at 4 clocks per bit
// with a behavioural FIFO that returns data one cycle after fifo_rd.
module tb_fifo_uart_drain;

    localparam int CPB = 4;
    localparam int DW  = 32;
    localparam int HN  = 8192;

    logic          clk;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd;
    logic          tx;
    logic          busy;
    logic          word_done;

    int compared;
    int mismatched;
    int cyc;

    // FIFO model: pushes from the stimulus process, pops on fifo_rd.
    logic [DW-1:0] mem_arr [0:63];
    int            push_cnt;
    int            pop_cnt;
    logic          force_ne;

    // Per-cycle history of DUT outputs, indexed by cycle number.
    logic tx_h   [0:HN-1];
    logic rd_h   [0:HN-1];
    logic busy_h [0:HN-1];
    logic wd_h   [0:HN-1];

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;

    vec_t vecs [5];

    fifo_uart_drain #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .word_done  (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt) && !force_ne;

    // Registered-read FIFO: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd && (push_cnt != pop_cnt)) begin
            fifo_data <= mem_arr[pop_cnt];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record outputs shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (cyc >= 0 && cyc < HN) begin
            tx_h[cyc]   = tx;
            rd_h[cyc]   = fifo_rd;
            busy_h[cyc] = busy;
            wd_h[cyc]   = word_done;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        mem_arr[push_cnt] = w;
        push_cnt = push_cnt + 1;
    endtask

    function automatic logic h_tx(input int i);
        if (i < 0 || i >= HN) return 1'bx;
        return tx_h[i];
    endfunction

    function automatic logic h_rd(input int i);
        if (i < 0 || i >= HN) return 1'bx;
        return rd_h[i];
    endfunction

    function automatic logic h_busy(input int i);
        if (i < 0 || i >= HN) return 1'bx;
        return busy_h[i];
    endfunction

    function automatic logic h_wd(input int i);
        if (i < 0 || i >= HN) return 1'bx;
        return wd_h[i];
    endfunction

    function automatic int find_rd(input int a, input int b);
        for (int i = a; i <= b; i++) if (h_rd(i) === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_rd(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) if (h_rd(i) === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_wd(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) if (h_wd(i) === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_not_idle(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) if (h_tx(i) !== 1'b1 || h_busy(i) !== 1'b0) n++;
        return n;
    endfunction

    // Decode the four frames of a word whose FETCH cycle is f; each frame is
    // start(0), 8 data bits LSB first, stop(1), CPB cycles per bit.
    task automatic check_word(input string name, input int f, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            int         s;
            int         errs;
            int         bi;
            logic [7:0] exp_b;
            logic [7:0] got;
            logic       e;
            s     = f + 2 + 10 * CPB * b;
            exp_b = w[8*b +: 8];
            errs  = 0;
            for (int k = 0; k < 10 * CPB; k++) begin
                bi = k / CPB;
                if (bi == 0)      e = 1'b0;
                else if (bi == 9) e = 1'b1;
                else              e = exp_b[bi-1];
                if (h_tx(s + k) !== e) errs++;
            end
            for (int i = 0; i < 8; i++) got[i] = h_tx(s + CPB + CPB * i + CPB / 2);
            check($sformatf("%s_byte%0d", name, b), {24'd0, got}, {24'd0, exp_b});
            check($sformatf("%s_frame%0d_timing", name, b), 32'(errs), 32'd0);
        end
    endtask

    initial begin
        int c;
        int f;
        int f2;
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        push_cnt   = 0;
        pop_cnt    = 0;
        force_ne   = 1'b0;
        fifo_data  = '0;
        rst        = 1'b0;
        en         = 1'b0;

        vecs[0] = '{word: 32'hA55A0F01, b0: 8'h01, b1: 8'h0F, b2: 8'h5A, b3: 8'hA5};
        vecs[1] = '{word: 32'h00000000, b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00};
        vecs[2] = '{word: 32'hFFFFFFFF, b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF};
        vecs[3] = '{word: 32'h12345678, b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12};
        vecs[4] = '{word: 32'h80C33C01, b0: 8'h01, b1: 8'h3C, b2: 8'hC3, b3: 8'h80};

        // Reset held for three cycles, then idle with an empty FIFO.
        wait_cyc(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_word_done", {31'd0, word_done}, 32'd0);
        rst = 1'b1;
        en  = 1'b1;
        c   = cyc;
        wait_cyc(201);
        check("idle_empty_reads", 32'(count_rd(c + 1, c + 200)), 32'd0);
        check("idle_empty_activity", 32'(count_not_idle(c + 1, c + 200)), 32'd0);

        // Single words from the vector table.
        for (int v = 0; v < 5; v++) begin
            push(vecs[v].word);
            c = cyc;
            wait_cyc(10 * CPB * 4 + 10);
            f = find_rd(c, c + 10 * CPB * 4 + 9);
            check($sformatf("v%0d_rd_latency", v), 32'(f), 32'(c + 1));
            if (f < 0) f = c + 1;
            check($sformatf("v%0d_rd_count", v), 32'(count_rd(c, c + 10 * CPB * 4 + 9)), 32'd1);
            check($sformatf("v%0d_word_done_at", v), {31'd0, h_wd(f + 162)}, 32'd1);
            check($sformatf("v%0d_word_done_count", v), 32'(count_wd(c, c + 10 * CPB * 4 + 9)), 32'd1);
            check($sformatf("v%0d_busy_last", v), {31'd0, h_busy(f + 161)}, 32'd1);
            check($sformatf("v%0d_busy_after", v), {31'd0, h_busy(f + 162)}, 32'd0);
            check($sformatf("v%0d_tx_fall", v), {31'd0, h_tx(f + 1)}, 32'd1);
            check_word($sformatf("v%0d", v), f, {vecs[v].b3, vecs[v].b2, vecs[v].b1, vecs[v].b0});
        end

        // Back-to-back words: exactly two idle-high cycles between them.
        push(32'h00000000);
        push(32'hFFFFFFFF);
        c = cyc;
        wait_cyc(340);
        f = find_rd(c, c + 339);
        check("b2b_rd_latency", 32'(f), 32'(c + 1));
        if (f < 0) f = c + 1;
        check("b2b_rd_count", 32'(count_rd(c, c + 339)), 32'd2);
        f2 = find_rd(f + 1, c + 339);
        check("b2b_rd_spacing", 32'(f2 - f), 32'd162);
        check("b2b_gap0", {31'd0, h_tx(f + 162)}, 32'd1);
        check("b2b_gap1", {31'd0, h_tx(f + 163)}, 32'd1);
        check("b2b_next_start", {31'd0, h_tx(f + 164)}, 32'd0);
        check("b2b_word_done", {31'd0, h_wd(f + 162)}, 32'd1);
        check("b2b_busy_fetch", {31'd0, h_busy(f + 162)}, 32'd1);
        check_word("b2b_w0", f, 32'h00000000);
        check_word("b2b_w1", f + 162, 32'hFFFFFFFF);

        // en dropped during byte 1 with a second word queued.
        push(32'h12345678);
        push(32'hCAFEF00D);
        c = cyc;
        f = c + 1;
        wait_cyc(51);
        en = 1'b0;
        wait_cyc(200);
        check("en_rd_count", 32'(count_rd(c, f + 250)), 32'd1);
        check("en_rd_at", {31'd0, h_rd(f)}, 32'd1);
        check("en_word_done", {31'd0, h_wd(f + 162)}, 32'd1);
        check("en_busy_idle", {31'd0, h_busy(f + 163)}, 32'd0);
        check_word("en_w0", f, 32'h12345678);
        en = 1'b1;
        c  = cyc;
        wait_cyc(175);
        f2 = find_rd(c, c + 174);
        check("en_resume_latency", 32'(f2), 32'(c + 1));
        if (f2 < 0) f2 = c + 1;
        check_word("en_w1", f2, 32'hCAFEF00D);

        // Asynchronous reset in the middle of byte 2 (all-zero byte).
        push(32'h55001234);
        c = cyc;
        f = c + 1;
        wait_cyc(91);
        check("arst_tx_low_before", {31'd0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        check("arst_tx_now", {31'd0, tx}, 32'd1);
        check("arst_busy_now", {31'd0, busy}, 32'd0);
        check("arst_rd_now", {31'd0, fifo_rd}, 32'd0);
        wait_cyc(2);
        rst = 1'b1;
        c   = cyc;
        wait_cyc(100);
        check("arst_no_reread", 32'(count_rd(c, c + 99)), 32'd0);
        check("arst_idle_after", 32'(count_not_idle(c + 1, c + 99)), 32'd0);
        push(32'h3C5AA5C3);
        c = cyc;
        wait_cyc(175);
        f = find_rd(c, c + 174);
        check("arst_next_latency", 32'(f), 32'(c + 1));
        if (f < 0) f = c + 1;
        check_word("arst_next", f, 32'h3C5AA5C3);

        // FIFO reports non-empty until the very edge that ends the last stop bit.
        push(32'h000000FF);
        force_ne = 1'b1;
        c = cyc;
        f = c + 1;
        wait_cyc(162);
        force_ne = 1'b0;
        wait_cyc(100);
        check("empty_rd_count", 32'(count_rd(c, f + 260)), 32'd1);
        check("empty_word_done", {31'd0, h_wd(f + 162)}, 32'd1);
        check("empty_busy_after", {31'd0, h_busy(f + 162)}, 32'd0);
        check("empty_idle_after", 32'(count_not_idle(f + 163, f + 260)), 32'd0);
        check_word("empty_w", f, 32'h000000FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
